// File: rtl/req_ack_requester.sv
// Upstream requester for the req/ack handshake: latches a command, pulses req for one
// cycle per attempt, waits a bounded window for ack, retries, then reports done or error.
module req_ack_requester #(
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 4,
    parameter int MAX_RETRY = 2,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              ack,
    output logic              req,
    output logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [RW-1:0]     retry_cnt,
    output logic              spur_ack,
    output logic [2:0]        state_dbg   // 0 IDLE, 1 REQ, 2 WAIT, 3 DONE, 4 ERR
);

    // Handshake: req is high for exactly one cycle per attempt; the responder answers with
    // ack on a later cycle (never the req cycle itself) within TIMEOUT WAIT cycles.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [WW-1:0]     wcnt, wcnt_nx;
    logic              req_nx, busy_nx, done_nx, err_nx, spur_nx;
    logic [DATA_W-1:0] req_data_nx;
    logic [RW-1:0]     retry_nx;
    logic              window_end, can_retry;

    assign window_end = (wcnt == WW'(TIMEOUT));
    assign can_retry  = (retry_cnt < RW'(MAX_RETRY));
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            req         <= 1'b0;
            req_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
            spur_ack    <= 1'b0;
        end else begin
            state       <= state_nx;
            wcnt        <= wcnt_nx;
            req         <= req_nx;
            req_data    <= req_data_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            timeout_err <= err_nx;
            retry_cnt   <= retry_nx;
            spur_ack    <= spur_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_REQ;
            S_REQ:  state_nx = S_WAIT;
            S_WAIT: begin
                // ack wins over a timeout landing on the same edge
                if (ack)             state_nx = S_DONE;
                else if (window_end) state_nx = can_retry ? S_REQ : S_ERR;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_nx      = (state_nx == S_REQ);
        busy_nx     = (state_nx != S_IDLE);
        done_nx     = (state_nx == S_DONE);
        err_nx      = (state_nx == S_ERR);
        req_data_nx = req_data;
        retry_nx    = retry_cnt;
        wcnt_nx     = wcnt;
        // An ack before the first WAIT cycle cannot belong to the current request.
        spur_nx     = spur_ack | (ack & ((state == S_IDLE) | (state == S_REQ)));
        case (state)
            S_IDLE: begin
                if (start) begin
                    req_data_nx = cmd_data;
                    retry_nx    = '0;
                end
            end
            S_REQ: wcnt_nx = WW'(1);
            S_WAIT: begin
                if (!ack) begin
                    if (window_end) begin
                        if (can_retry) retry_nx = retry_cnt + RW'(1);
                    end else begin
                        wcnt_nx = wcnt + WW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_req_ack_requester.sv
// Bench for req_ack_requester: directed scenarios plus random ack/start patterns checked
// against a timeline model (attempt k requests at edge k*(TIMEOUT+1), answers allowed 2..TIMEOUT+1 later).
module tb_req_ack_requester;

    localparam int W   = 8;
    localparam int T   = 4;
    localparam int MR  = 2;
    localparam int RW  = 2;
    localparam int LEN = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  cmd_data;
    logic          ack;
    logic          req;
    logic [W-1:0]  req_data;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [RW-1:0] retry_cnt;
    logic          spur_ack;
    logic [2:0]    state_dbg;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic          exp_spur = 1'b0;
    logic [W-1:0]  exp_q[$];

    req_ack_requester #(.DATA_W(W), .TIMEOUT(T), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_data(cmd_data), .ack(ack),
        .req(req), .req_data(req_data), .busy(busy), .done(done),
        .timeout_err(timeout_err), .retry_cnt(retry_cnt), .spur_ack(spur_ack),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Edge 0 is the edge that samples the command strobe; ack_m[r] / st_m[r] are the
    // input values sampled at edge r; outputs are observed 1ns after each edge.
    task automatic run_txn(input string name, input logic [W-1:0] data,
                           input logic [31:0] ack_m, input logic [31:0] st_m_in,
                           input logic [W-1:0] data2);
        logic [31:0]   e_req, e_done, e_err, e_busy, st_m;
        logic [31:0]   req_o, done_o, err_o, busy_o;
        logic [RW-1:0] e_retry;
        logic [W-1:0]  e_data;
        logic          found;
        int            fin, base;
        e_req = '0; e_done = '0; e_err = '0; e_busy = '0;
        req_o = '0; done_o = '0; err_o = '0; busy_o = '0;
        found = 1'b0; fin = 0; e_retry = '0;
        if (ack_m[0]) exp_spur = 1'b1;
        for (int k = 0; k <= MR; k++) begin
            if (!found) begin
                base = k * (T + 1);
                e_req[base] = 1'b1;
                if (ack_m[base + 1]) exp_spur = 1'b1;
                for (int r = base + 2; r <= base + 1 + T; r++) begin
                    if (!found && ack_m[r]) begin
                        found = 1'b1; fin = r; e_retry = RW'(k);
                    end
                end
            end
        end
        if (found) e_done[fin] = 1'b1;
        else begin
            fin = (MR + 1) * (T + 1);
            e_err[fin] = 1'b1;
            e_retry = RW'(MR);
        end
        for (int r = 0; r <= fin; r++) e_busy[r] = 1'b1;
        for (int r = fin + 2; r < LEN; r++) if (ack_m[r]) exp_spur = 1'b1;
        // extra strobes only while the block is occupied; they must be ignored
        st_m = '0;
        for (int r = 1; r <= fin + 1; r++) st_m[r] = st_m_in[r];
        exp_q.push_back(data);

        start = 1'b1; cmd_data = data; ack = ack_m[0];
        for (int r = 0; r < LEN; r++) begin
            @(posedge clk); #1;
            req_o[r] = req; done_o[r] = done; err_o[r] = timeout_err; busy_o[r] = busy;
            start    = st_m[r + 1];
            cmd_data = st_m[r + 1] ? data2 : data;
            ack      = ack_m[r + 1];
        end
        start = 1'b0; ack = 1'b0;

        e_data = exp_q.pop_front();
        n_checks++;
        if (req_o !== e_req) $display("FAIL %s req_edges: got %h expected %h", name, req_o, e_req);
        else n_pass++;
        n_checks++;
        if (done_o !== e_done) $display("FAIL %s done_edges: got %h expected %h", name, done_o, e_done);
        else n_pass++;
        n_checks++;
        if (err_o !== e_err) $display("FAIL %s timeout_err_edges: got %h expected %h", name, err_o, e_err);
        else n_pass++;
        n_checks++;
        if (busy_o !== e_busy) $display("FAIL %s busy_edges: got %h expected %h", name, busy_o, e_busy);
        else n_pass++;
        n_checks++;
        if (req_data !== e_data) $display("FAIL %s req_data: got %h expected %h", name, req_data, e_data);
        else n_pass++;
        n_checks++;
        if (retry_cnt !== e_retry) $display("FAIL %s retry_cnt: got %0d expected %0d", name, retry_cnt, e_retry);
        else n_pass++;
        n_checks++;
        if (spur_ack !== exp_spur) $display("FAIL %s spur_ack: got %b expected %b", name, spur_ack, exp_spur);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ack = 1'b0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req, busy, done, timeout_err, spur_ack} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {req, busy, done, timeout_err, spur_ack});
        else n_pass++;
        n_checks++;
        if ({req_data, retry_cnt} !== '0)
            $display("FAIL reset_regs: got req_data=%h retry_cnt=%0d expected 0", req_data, retry_cnt);
        else n_pass++;
        n_checks++;
        if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg);
        else n_pass++;
        rst = 1'b0;
        exp_spur = 1'b0;
    endtask

    task automatic test_directed();
        run_txn("ack_first_edge",  8'hA5, 32'h0000_0004, 32'h0, 8'h00);
        run_txn("ack_third_edge",  8'hA5, 32'h0000_0010, 32'h0, 8'h00);
        run_txn("ack_last_edge",   8'h11, 32'h0000_0020, 32'h0, 8'h00);
        run_txn("no_ack",          8'h5A, 32'h0000_0000, 32'h0, 8'h00);
        run_txn("ack_after_retry", 8'h77, 32'h0000_0080, 32'h0, 8'h00);
        run_txn("ack_final_edge",  8'hE1, 32'h0000_8000, 32'h0, 8'h00);
    endtask

    task automatic test_protocol();
        run_txn("spur_and_restart", 8'hA5, 32'h0000_0006, 32'h0000_0002, 8'h3C);
    endtask

    task automatic test_reset_mid();
        logic seen_done, seen_err;
        seen_done = 1'b0; seen_err = 1'b0;
        start = 1'b1; cmd_data = 8'h5A; ack = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(posedge clk); #1;
            seen_done |= done; seen_err |= timeout_err;
            if (r == 2) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy);
                else n_pass++;
            end
            if (r == 3) begin
                n_checks++;
                if ({req, busy, done, timeout_err, spur_ack, req_data, retry_cnt, state_dbg} !== '0)
                    $display("FAIL midrst_outputs: got req=%b busy=%b req_data=%h retry=%0d state=%0d expected 0",
                             req, busy, req_data, retry_cnt, state_dbg);
                else n_pass++;
            end
            start = 1'b0;
            rst   = (r == 2);
        end
        n_checks++;
        if ({seen_done, seen_err} !== 2'b00)
            $display("FAIL midrst_no_pulse: got done=%b err=%b expected 0", seen_done, seen_err);
        else n_pass++;
        exp_spur = 1'b0;
        run_txn("after_reset", 8'hC3, 32'h0000_0004, 32'h0, 8'h00);
    endtask

    task automatic test_random();
        logic [31:0] ack_m, st_m;
        for (int i = 0; i < 40; i++) begin
            ack_m = '0; st_m = '0;
            for (int r = (i < 20) ? 2 : 0; r < LEN; r++) ack_m[r] = ($urandom_range(0, 6) == 0);
            for (int r = 1; r < LEN; r++) st_m[r] = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", i), W'($urandom), ack_m, st_m, W'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
